// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared between the fetch stage and the
// fetch/decode queue.
package cpu_pkg;

  // Instruction shown to decode when nothing valid is available (opcode 5'b01111).
  localparam logic [31:0] CPU_NOP_INSTR = 32'h7800_0000;

  // PC presented by the queue after reset or flush.
  localparam logic [31:0] CPU_PC_RESET  = 32'h0600_2000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fd_entry_t;

endpackage

// File: rtl/fd_queue_storage.sv
// fd_queue_storage: DEPTH-entry {instr, pc} register array with one write
// port and one asynchronous read port. Holds data only; no reset needed.
module fd_queue_storage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fd_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fd_entry_t     rdata
);

  fd_entry_t mem [DEPTH];

  // Write the selected entry on a granted push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: elastic {instr, pc} buffer between fetch and decode.
// Fetch pushes with if_valid and is held off by if_stall; decode pops the
// head with id_valid/id_ready. flush empties the queue back to NOP/PC_RESET.
// Optional macro FETCH_DECODE_QUEUE_BYPASS_EN: an instruction arriving at an
// empty queue is forwarded combinationally to decode (zero-cycle latency).
module fetch_decode_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR,
  parameter logic [31:0] PC_RESET  = CPU_PC_RESET
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [31:0]                if_instr,
  input  logic [31:0]                if_pc,
  output logic                       if_stall,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [31:0]                id_instr,
  output logic [31:0]                id_pc,
  output logic [$clog2(DEPTH+1)-1:0] id_count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic [31:0]   last_pc;
  fd_entry_t     head;
  fd_entry_t     wdata;
  logic          empty, full, byp;
  logic          pop, push, mem_push, mem_pop;

  assign wdata    = '{instr: if_instr, pc: if_pc};
  assign id_count = count;

  fd_queue_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (mem_push),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (head)
  );

  // Handshake decode, head/NOP output selection and stall generation.
  always_comb begin
    empty = (count == '0);
    full  = (count == FULL_CNT);
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    byp   = empty && if_valid && !flush;
`else
    byp   = 1'b0;
`endif
    id_valid = !empty || byp;
    id_instr = NOP_INSTR;
    id_pc    = last_pc;
    if (!empty) begin
      id_instr = head.instr;
      id_pc    = head.pc;
    end else if (byp) begin
      id_instr = if_instr;
      id_pc    = if_pc;
    end
    pop  = id_valid && id_ready;
    // Pushing into a full queue is only legal when the head leaves this cycle.
    push = if_valid && !flush && (!full || pop);
    // A bypassed instruction consumed in the same cycle never touches storage.
    mem_pop  = pop && !byp;
    mem_push = push && !(byp && pop);
    if_stall = full && !id_ready;
  end

  // Pointer, occupancy and last-popped-PC state; flush dominates push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      last_pc <= PC_RESET;
    end else if (flush) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      last_pc <= PC_RESET;
    end else begin
      if (mem_push) wptr <= wptr + AW'(1);
      if (mem_pop)  rptr <= rptr + AW'(1);
      if (mem_push && !mem_pop)      count <= count + CW'(1);
      else if (mem_pop && !mem_push) count <= count - CW'(1);
      if (pop) last_pc <= id_pc;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed and randomized checks of fetch_decode_queue
// against a queue-based reference model of the buffer's rules.
module tb_fetch_decode_queue;
  import cpu_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h7800_0000;
  localparam logic [31:0] PCR   = 32'h0600_2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_stall;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [1:0]  id_count;

  int total = 0;
  int bad   = 0;

  fd_entry_t   mq [$];
  logic [31:0] m_last;
  logic        e_valid, e_byp;
  logic [31:0] e_pc, d_pc;
  bit          acc;
  logic [31:0] pops [$];
  int          maxcnt;
  int          idx;

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .if_stall (if_stall),
    .id_ready (id_ready),
    .id_valid (id_valid),
    .id_instr (id_instr),
    .id_pc    (id_pc),
    .id_count (id_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs and compare outputs with the model's view.
  task automatic drive_check(input bit fl, input bit v, input logic [31:0] ins,
                             input logic [31:0] pc, input bit rdy);
    int sz;
    logic [31:0] ei, ep;
    flush = fl; if_valid = v; if_instr = ins; if_pc = pc; id_ready = rdy;
    #1;
    sz    = mq.size();
    e_byp = 1'b0;
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    e_byp = (sz == 0) && v && !fl;
`endif
    e_valid = (sz > 0) || e_byp;
    if (sz > 0) begin
      ei = mq[0].instr; ep = mq[0].pc;
    end else if (e_byp) begin
      ei = ins; ep = pc;
    end else begin
      ei = NOP; ep = m_last;
    end
    e_pc = ep;
    d_pc = id_pc;
    chk("valid", {31'b0, id_valid}, {31'b0, e_valid});
    chk("instr", id_instr, ei);
    chk("pc",    id_pc, ep);
    chk("count", {30'b0, id_count}, 32'(sz));
    chk("stall", {31'b0, if_stall}, {31'b0, (sz == DEPTH) && !rdy});
  endtask

  // Apply the queue rules to the model, then step to just after the next edge.
  task automatic advance();
    bit pop;
    acc = 1'b0;
    if (flush) begin
      mq.delete();
      m_last = PCR;
    end else begin
      pop = e_valid && id_ready;
      acc = if_valid && ((mq.size() < DEPTH) || pop);
      if (pop) begin
        pops.push_back(d_pc);
        m_last = e_pc;
      end
      if (!(e_byp && pop)) begin
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back('{instr: if_instr, pc: if_pc});
      end
    end
    @(posedge clk);
    #1;
    if (int'(id_count) > maxcnt) maxcnt = int'(id_count);
  endtask

  task automatic cyc(input bit fl, input bit v, input logic [31:0] ins,
                     input logic [31:0] pc, input bit rdy);
    drive_check(fl, v, ins, pc, rdy);
    advance();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; id_ready = 1'b0;
    mq.delete(); m_last = PCR; maxcnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc",    id_pc, PCR);
    chk("rst_count", {30'b0, id_count}, 32'd0);
    chk("rst_stall", {31'b0, if_stall}, 32'd0);

    // Single push, visible one cycle later
    cyc(0, 1, 32'h1234_5678, 32'h0600_2000, 0);
    chk("push1_valid", {31'b0, id_valid}, 32'd1);
    chk("push1_instr", id_instr, 32'h1234_5678);
    chk("push1_count", {30'b0, id_count}, 32'd1);

    // Asynchronous reset mid-cycle with one entry held
    #2;
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0; rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, id_valid}, 32'd0);
    chk("arst_instr", id_instr, NOP);
    chk("arst_pc",    id_pc, PCR);
    chk("arst_count", {30'b0, id_count}, 32'd0);
    chk("arst_stall", {31'b0, if_stall}, 32'd0);
    #1 rst_n = 1'b1;
    mq.delete(); m_last = PCR;
    @(posedge clk); #1;

    // Fill and back-pressure
    cyc(0, 1, 32'hA000_0000, 32'h0600_2000, 0);
    cyc(0, 1, 32'hA000_0004, 32'h0600_2004, 0);
    chk("full_count", {30'b0, id_count}, 32'd2);
    chk("full_stall", {31'b0, if_stall}, 32'd1);
    cyc(0, 1, 32'hA000_0008, 32'h0600_2008, 0);
    chk("refused_count", {30'b0, id_count}, 32'd2);
    chk("refused_head",  id_pc, 32'h0600_2000);
    cyc(0, 1, 32'hA000_0008, 32'h0600_2008, 1);
    chk("pushpop_stall", {31'b0, if_stall}, 32'd0);
    chk("pushpop_count", {30'b0, id_count}, 32'd2);
    chk("pop_order1", id_pc, 32'h0600_2004);
    cyc(0, 0, 32'h0, 32'h0, 1);
    chk("pop_order2", id_pc, 32'h0600_2008);
    cyc(0, 0, 32'h0, 32'h0, 1);
    chk("drained_count", {30'b0, id_count}, 32'd0);
    chk("drained_pc",    id_pc, 32'h0600_2008);

    // Flush while full, with a same-cycle push
    cyc(0, 1, 32'hB000_0000, 32'h0600_3000, 0);
    cyc(0, 1, 32'hB000_0004, 32'h0600_3004, 0);
    cyc(1, 1, 32'hB000_0008, 32'h0600_3008, 0);
    chk("flush_count", {30'b0, id_count}, 32'd0);
    chk("flush_valid", {31'b0, id_valid}, 32'd0);
    chk("flush_instr", id_instr, NOP);
    chk("flush_pc",    id_pc, PCR);

    // Wrap-around stream with id_ready toggling 1,0,1,0...
    pops.delete(); maxcnt = 0; idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx < 8) cyc(0, 1, 32'hC000_0000 + 32'(idx), PCR + 32'(4 * idx), (c % 2) == 0);
      else         cyc(0, 0, 32'h0, 32'h0, (c % 2) == 0);
      if (acc && idx < 8) idx++;
    end
    chk("wrap_accepted", 32'(idx), 32'd8);
    chk("wrap_popped",   32'(pops.size()), 32'd8);
    for (int i = 0; i < 8 && i < pops.size(); i++)
      chk("wrap_order", pops[i], PCR + 32'(4 * i));
    chk("wrap_max_over2", {31'b0, maxcnt > 2}, 32'd0);

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    // Bypass through an empty queue
    cyc(1, 0, 32'h0, 32'h0, 0);
    drive_check(0, 1, 32'hCAFE_0001, 32'h0600_4000, 1);
    chk("byp_valid", {31'b0, id_valid}, 32'd1);
    chk("byp_instr", id_instr, 32'hCAFE_0001);
    advance();
    chk("byp_count", {30'b0, id_count}, 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
          $urandom, $urandom, $urandom_range(0, 1) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Elastic instruction buffer between the fetch stage and the decode stage.
- Captures each valid {instruction, PC} pair from fetch into a small FIFO and presents the head to decode with a valid/ready handshake.
- Back-pressures fetch with a stall when full; empties to NOP on a branch flush.
- Decouples fetch memory latency (Done) from decode stalls.

Parameters:
- DEPTH, 2, number of queue entries; power of two, minimum 2.
- NOP_INSTR, 32'h7800_0000, instruction presented when the queue is empty or flushed (opcode 5'b01111, all other bits 0).
- PC_RESET, 32'h0600_2000, value of id_pc when empty and out of reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  branch flush; synchronously discards all entries and the same-cycle push.
- if_valid  in  1  fetch has a valid instruction this cycle (fetch Done, or an injected instruction).
- if_instr  in  32  instruction from fetch.
- if_pc  in  32  PC of if_instr.
- if_stall  out  1  to fetch: queue cannot accept; fetch holds its PC.
- id_ready  in  1  decode can accept the head this cycle.
- id_valid  out  1  head entry is valid.
- id_instr  out  32  head instruction, or NOP_INSTR when !id_valid.
- id_pc  out  32  head PC, or last popped PC when !id_valid (PC_RESET after reset/flush).
- id_count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: DEPTH x {instr, pc} registers. Read pointer, write pointer and count are registers. Pointers wrap modulo DEPTH.
- pop = id_valid && id_ready.
- push = if_valid && !flush && (count < DEPTH || pop). Push while full is allowed only together with a pop.
- if_stall = (count == DEPTH) && !id_ready. Combinational; no dependence on if_valid.
- Push latency is 1 cycle: an entry written at edge N is visible at id_* after edge N.
- Count update on each edge:
  - push && !pop: +1
  - pop && !push: -1
  - both: unchanged, both pointers advance
  - neither: unchanged
- Empty (count == 0):
  - id_valid = 0, id_instr = NOP_INSTR.
  - A pop cannot occur.
  - Push on empty writes entry 0 at the write pointer.
- Full (count == DEPTH):
  - A push without a pop is refused and the data is not written.
  - Fetch must hold if_instr/if_pc while if_stall is high.
- flush:
  - Next edge sets rptr = wptr = 0, count = 0, id_pc = PC_RESET.
  - Same-cycle push and pop have no effect.
  - Flush dominates everything except reset.
  - id_* outputs during the flush cycle still show the current head; decode ignores them via its own flush.
- Reset (asynchronous, any time, including mid-push or while full): pointers = 0, count = 0, id_valid = 0, id_instr = NOP_INSTR, id_pc = PC_RESET, if_stall = 0.
- No state machine beyond the pointer/count datapath. Occupancy fully defines the state: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).

Optional Feature:
- Macro FETCH_DECODE_QUEUE_BYPASS_EN.
- Defined: when count == 0 && if_valid && !flush, if_instr/if_pc pass combinationally to id_* with id_valid = 1.
  - If id_ready is also high, the instruction is consumed in the same cycle and not written (count stays 0).
  - Otherwise it is written as a normal push.
  - Zero-cycle latency through an empty queue.
- Undefined: every instruction is written first; minimum latency is 1 cycle.

Decomposition:
- Shared package (cpu_pkg) holds:
  - NOP_INSTR and PC_RESET constants, shared with the fetch stage.
  - typedef fd_entry_t {logic [31:0] instr; logic [31:0] pc;}.
- One sub-module, fd_queue_storage: the DEPTH-entry register array with write port (we, waddr, wdata) and read port (raddr, rdata). Pointer/count control stays in the top module.

Test Plan:
- Reset then idle: assert rst_n low mid-cycle -> immediately id_valid = 0, id_instr = 32'h7800_0000, id_pc = 32'h0600_2000, id_count = 0, if_stall = 0.
- Single push: if_valid = 1, if_instr = 32'h1234_5678, if_pc = 32'h0600_2000, id_ready = 0 -> next cycle id_valid = 1, id_instr = 32'h1234_5678, id_count = 1.
- Fill and back-pressure:
  - Push PCs 0x0600_2000 and 0x0600_2004 with id_ready = 0 -> id_count = 2, if_stall = 1.
  - A third push with PC 0x0600_2008 is not stored.
  - Raising id_ready -> if_stall = 0. Simultaneous push/pop keeps count 2; pop order is 2000, 2004, 2008.
- Flush while full: count = 2, assert flush together with if_valid -> next cycle count = 0, id_valid = 0, id_instr = NOP, id_pc = 0x0600_2000.
- Wrap-around: stream 8 instructions at 1/cycle with id_ready toggling 1,0,1,0 -> output order and PCs match input exactly; count never exceeds 2.
- Bypass (macro defined): empty queue, if_valid = 1, id_ready = 1, instr 32'hCAFE_0001 -> same cycle id_valid = 1, id_instr = 32'hCAFE_0001; next cycle count = 0.
